// File: rtl/pq_issuer_pkg.sv
// Shared types and default settle gaps for the priority-queue operation issuer.
package pq_issuer_pkg;

    typedef enum logic [1:0] {
        OP_ILLEGAL = 2'b00,
        OP_ENQ     = 2'b01,
        OP_DEQ     = 2'b10,
        OP_REP     = 2'b11
    } pq_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } issuer_state_t;

    localparam int DEF_QUEUE_SIZE = 8;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ENQ_GAP    = 2;
    localparam int DEF_DEQ_GAP    = 3;
    localparam int DEF_REP_GAP    = 2;

endpackage

// File: rtl/pq_op_issuer.sv
// Front end for the max-first systolic queue: one op at a time, legality check,
// single-cycle queue pulses with settle gaps, and a held response.
//
// state | meaning
// IDLE  | ready for a request; top-of-queue snapshot taken at handshake
// ISSUE | queue pulse on o_q_wrt/o_q_read is visible this cycle
// WAIT  | counting down the op's settle gap, queue pins idle
// RESP  | response held until i_rsp_ready
module pq_op_issuer
    import pq_issuer_pkg::*;
#(
    parameter int QUEUE_SIZE = DEF_QUEUE_SIZE,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ENQ_GAP    = DEF_ENQ_GAP,
    parameter int DEQ_GAP    = DEF_DEQ_GAP,
    parameter int REP_GAP    = DEF_REP_GAP
) (
    input  logic                                i_CLK,
    input  logic                                i_RSTn,
    input  logic                                i_req_valid,
    output logic                                o_req_ready,
    input  logic [1:0]                          i_req_op,
    input  logic [DATA_WIDTH-1:0]               i_req_data,
    output logic                                o_rsp_valid,
    input  logic                                i_rsp_ready,
    output logic [1:0]                          o_rsp_op,
    output logic [DATA_WIDTH-1:0]               o_rsp_data,
    output logic                                o_rsp_err,
    output logic                                o_q_wrt,
    output logic                                o_q_read,
    output logic [DATA_WIDTH-1:0]               o_q_data,
    input  logic                                i_q_full,
    input  logic                                i_q_empty,
    input  logic [DATA_WIDTH-1:0]               i_q_top,
    output logic [$clog2(QUEUE_SIZE+1)-1:0]     o_count
);

    localparam int CW = $clog2(QUEUE_SIZE + 1);
    localparam int GW = 8;

    issuer_state_t         state, state_nxt;
    pq_op_t                op_q, op_nxt, req_op;
    logic [DATA_WIDTH-1:0] data_q, data_nxt, top_q, top_nxt;
    logic [GW-1:0]         gap_cnt, gap_nxt;
    logic                  q_wrt_nxt, q_read_nxt;
    logic [DATA_WIDTH-1:0] q_data_nxt;
    logic                  rsp_valid_nxt, rsp_err_nxt;
    logic [1:0]            rsp_op_nxt;
    logic [DATA_WIDTH-1:0] rsp_data_nxt;
    logic [CW-1:0]         count_nxt;
    logic                  req_err;
    logic                  op_done;

    function automatic logic [GW-1:0] gap_of(input pq_op_t op);
        case (op)
            OP_ENQ:  gap_of = GW'(ENQ_GAP);
            OP_DEQ:  gap_of = GW'(DEQ_GAP);
            OP_REP:  gap_of = GW'(REP_GAP);
            default: gap_of = '0;
        endcase
    endfunction

    assign o_req_ready = (state == IDLE);
    assign req_op      = pq_op_t'(i_req_op);
    assign req_err     = (req_op == OP_ILLEGAL)
                       | ((req_op == OP_ENQ) & i_q_full)
                       | (((req_op == OP_DEQ) | (req_op == OP_REP)) & i_q_empty);

    always_comb begin
        state_nxt     = state;
        op_nxt        = op_q;
        data_nxt      = data_q;
        top_nxt       = top_q;
        gap_nxt       = gap_cnt;
        q_wrt_nxt     = 1'b0;
        q_read_nxt    = 1'b0;
        q_data_nxt    = '0;
        rsp_valid_nxt = o_rsp_valid;
        rsp_op_nxt    = o_rsp_op;
        rsp_data_nxt  = o_rsp_data;
        rsp_err_nxt   = o_rsp_err;
        count_nxt     = o_count;
        op_done       = 1'b0;

        case (state)
            IDLE: begin
                if (i_req_valid) begin
                    op_nxt   = req_op;
                    data_nxt = i_req_data;
                    top_nxt  = i_q_top;
                    if (req_err) begin
                        state_nxt     = RESP;
                        rsp_valid_nxt = 1'b1;
                        rsp_op_nxt    = i_req_op;
                        rsp_data_nxt  = '0;
                        rsp_err_nxt   = 1'b1;
                    end else begin
                        // Pulse is registered here so it shows during the ISSUE cycle.
                        state_nxt  = ISSUE;
                        q_wrt_nxt  = (req_op == OP_ENQ) | (req_op == OP_REP);
                        q_read_nxt = (req_op == OP_DEQ) | (req_op == OP_REP);
                        q_data_nxt = i_req_data;
                        if ((req_op == OP_ENQ) && (o_count != CW'(QUEUE_SIZE)))
                            count_nxt = o_count + CW'(1);
                        else if ((req_op == OP_DEQ) && (o_count != '0))
                            count_nxt = o_count - CW'(1);
                    end
                end
            end
            ISSUE: begin
                if (gap_of(op_q) == '0) begin
                    op_done = 1'b1;
                end else begin
                    state_nxt = WAIT;
                    gap_nxt   = gap_of(op_q);
                end
            end
            WAIT: begin
                if (gap_cnt <= GW'(1))
                    op_done = 1'b1;
                else
                    gap_nxt = gap_cnt - GW'(1);
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_nxt     = IDLE;
                    rsp_valid_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Successful REP returns the pre-replace max even if the new value is larger.
        if (op_done) begin
            state_nxt     = RESP;
            rsp_valid_nxt = 1'b1;
            rsp_op_nxt    = op_q;
            rsp_err_nxt   = 1'b0;
            rsp_data_nxt  = (op_q == OP_ENQ) ? '0 : top_q;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            state       <= IDLE;
            op_q        <= OP_ILLEGAL;
            data_q      <= '0;
            top_q       <= '0;
            gap_cnt     <= '0;
            o_q_wrt     <= 1'b0;
            o_q_read    <= 1'b0;
            o_q_data    <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_op    <= '0;
            o_rsp_data  <= '0;
            o_rsp_err   <= 1'b0;
            o_count     <= '0;
        end else begin
            state       <= state_nxt;
            op_q        <= op_nxt;
            data_q      <= data_nxt;
            top_q       <= top_nxt;
            gap_cnt     <= gap_nxt;
            o_q_wrt     <= q_wrt_nxt;
            o_q_read    <= q_read_nxt;
            o_q_data    <= q_data_nxt;
            o_rsp_valid <= rsp_valid_nxt;
            o_rsp_op    <= rsp_op_nxt;
            o_rsp_data  <= rsp_data_nxt;
            o_rsp_err   <= rsp_err_nxt;
            o_count     <= count_nxt;
        end
    end

endmodule

// File: tb/tb_pq_op_issuer.sv
// Directed and random checks of pq_op_issuer against a behavioural max-first queue
// and a sorted reference model feeding a response scoreboard.
module tb_pq_op_issuer;

    localparam int QS    = 8;
    localparam int DW    = 16;
    localparam int CW    = $clog2(QS + 1);
    localparam int GAP_E = 2;
    localparam int GAP_D = 3;
    localparam int GAP_R = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b00;
    logic [DW-1:0] req_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [1:0]    rsp_op;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          q_wrt, q_read;
    logic [DW-1:0] q_data;
    logic          q_full = 1'b0;
    logic          q_empty = 1'b1;
    logic [DW-1:0] q_top = '0;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    int            env_q[$];
    int            ref_q[$];
    int            wr_pulses = 0;
    int            rd_pulses = 0;
    logic          prev_pulse = 1'b0;
    logic [DW-1:0] last_wdata = '0;
    int            ek;

    typedef struct {
        logic [1:0]    op;
        logic [DW-1:0] data;
        logic          err;
        int            lat;
        int            cnt;
        int            wr;
        int            rd;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    pq_op_issuer #(
        .QUEUE_SIZE(QS), .DATA_WIDTH(DW),
        .ENQ_GAP(GAP_E), .DEQ_GAP(GAP_D), .REP_GAP(GAP_R)
    ) dut (
        .i_CLK(clk), .i_RSTn(rstn),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_op(req_op), .i_req_data(req_data),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_op(rsp_op), .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
        .o_q_wrt(q_wrt), .o_q_read(q_read), .o_q_data(q_data),
        .i_q_full(q_full), .i_q_empty(q_empty), .i_q_top(q_top),
        .o_count(count)
    );

    // Behavioural max-first queue attached to the issuer's queue pins.
    always @(posedge clk) begin
        if (!rstn) begin
            env_q.delete();
            prev_pulse = 1'b0;
        end else begin
            if (q_wrt || q_read) begin
                checks++;
                assert (!prev_pulse) else begin
                    errors++;
                    $error("FAIL back_to_back: observed pulse in consecutive cycles, expected idle gap");
                end
                if (q_read) begin
                    rd_pulses++;
                    if (env_q.size() > 0) void'(env_q.pop_front());
                end
                if (q_wrt) begin
                    wr_pulses++;
                    last_wdata = q_data;
                    ek = 0;
                    while (ek < env_q.size() && env_q[ek] >= int'(q_data)) ek++;
                    env_q.insert(ek, int'(q_data));
                end
            end
            prev_pulse = q_wrt || q_read;
        end
        q_full  <= (env_q.size() >= QS);
        q_empty <= (env_q.size() == 0);
        q_top   <= (env_q.size() > 0) ? DW'(env_q[0]) : '0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [1:0] op, input logic [DW-1:0] d, input int hold);
        exp_t e;
        exp_t got;
        int   lat;
        int   w0, r0, k;
        e.op   = op;
        e.err  = (op == 2'b00) || (op == 2'b01 && ref_q.size() == QS)
               || (op[1] && ref_q.size() == 0);
        e.data = (e.err || op == 2'b01) ? '0 : DW'(ref_q[0]);
        e.lat  = e.err ? 1 : (op == 2'b01) ? 2 + GAP_E : (op == 2'b10) ? 2 + GAP_D : 2 + GAP_R;
        e.wr   = (!e.err && op[0]) ? 1 : 0;
        e.rd   = (!e.err && op[1]) ? 1 : 0;
        if (!e.err) begin
            if (op[1]) void'(ref_q.pop_front());
            if (op[0]) begin
                k = 0;
                while (k < ref_q.size() && ref_q[k] >= int'(d)) k++;
                ref_q.insert(k, int'(d));
            end
        end
        e.cnt = ref_q.size();
        sb.push_back(e);

        w0 = wr_pulses;
        r0 = rd_pulses;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_data  = '0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: observed no response, expected response within 40 cycles");
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $fatal(1, "response timeout");
        end
        got = sb.pop_front();
        check("rsp_latency", 32'(lat), 32'(got.lat));
        check("rsp_op", 32'(rsp_op), 32'(got.op));
        check("rsp_data", 32'(rsp_data), 32'(got.data));
        check("rsp_err", 32'(rsp_err), 32'(got.err));
        check("count", 32'(count), 32'(got.cnt));
        if (got.wr == 1) check("q_wdata", 32'(last_wdata), 32'(d));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_data", 32'(rsp_data), 32'(got.data));
            check("hold_err", 32'(rsp_err), 32'(got.err));
            check("hold_ready", 32'(req_ready), 32'd0);
        end
        check("wr_pulses", 32'(wr_pulses - w0), 32'(got.wr));
        check("rd_pulses", 32'(rd_pulses - r0), 32'(got.rd));
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int w0, r0;
        int sel;
        logic [1:0] rop;

        // Reset state
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_q_wrt", 32'(q_wrt), 32'd0);
        check("rst_q_read", 32'(q_read), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);

        // Three enqueues, then drain
        do_op(2'b01, 16'd100, 0);
        do_op(2'b01, 16'd700, 0);
        do_op(2'b01, 16'd5, 0);
        check("count_after_enq", 32'(count), 32'd3);
        check("queue_top", 32'(q_top), 32'd700);
        do_op(2'b10, 16'd0, 0);
        do_op(2'b10, 16'd0, 0);
        do_op(2'b10, 16'd0, 0);
        check("count_after_deq", 32'(count), 32'd0);

        // Errors on empty queue and illegal opcode
        do_op(2'b10, 16'd0, 0);
        do_op(2'b11, 16'd42, 0);
        do_op(2'b00, 16'd7, 0);

        // Fill to capacity, overflow, replace
        for (int i = 1; i <= QS; i++) do_op(2'b01, DW'(i * 10), 0);
        do_op(2'b01, 16'd9, 0);
        check("count_full", 32'(count), 32'(QS));
        do_op(2'b11, 16'd1, 0);
        do_op(2'b10, 16'd0, 0);

        // Back-pressure on the response channel
        do_op(2'b11, 16'd900, 10);

        // Reset during WAIT
        w0 = wr_pulses;
        r0 = rd_pulses;
        req_valid = 1'b1;
        req_op    = 2'b10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 2'b00;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("mid_rst_q_wrt", 32'(q_wrt), 32'd0);
        check("mid_rst_q_read", 32'(q_read), 32'd0);
        check("mid_rst_q_data", 32'(q_data), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_rsp_op", 32'(rsp_op), 32'd0);
        check("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
        check("mid_rst_rsp_err", 32'(rsp_err), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        rstn = 1'b1;
        ref_q.delete();
        repeat (3) @(negedge clk);
        check("mid_rst_rd_pulses", 32'(rd_pulses - r0), 32'd1);
        check("mid_rst_wr_pulses", 32'(wr_pulses - w0), 32'd0);
        check("mid_rst_idle_valid", 32'(rsp_valid), 32'd0);

        // Random mix
        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(0, 9);
            rop = (sel == 0) ? 2'b00 : (sel <= 4) ? 2'b01 : (sel <= 7) ? 2'b10 : 2'b11;
            do_op(rop, DW'($urandom_range(0, 65535)), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
